// File: rtl/perf_monitor_if.sv
// Purpose: bundles the retirement/cache strobes, the clear/read controls and the monitor results.
// Latency: wires only, no storage.
// Backpressure: none; every strobe is a single-cycle qualified event.
interface perf_monitor_if #(
  parameter int CNT_W = 32
);
  logic             regWrite;
  logic             memWrite;
  logic             halt;
  logic             iCacheReq;
  logic             iCacheHit;
  logic             dCacheReq;
  logic             dCacheHit;
  logic             clear;
  logic [2:0]       rdSel;
  logic [CNT_W-1:0] rdData;
  logic             halted;
  logic             haltPulse;

  // Pipeline/debug side: drives events and read select, observes results.
  modport master (
    output regWrite, memWrite, halt, iCacheReq, iCacheHit, dCacheReq, dCacheHit,
    output clear, rdSel,
    input  rdData, halted, haltPulse
  );

  // Monitor side.
  modport slave (
    input  regWrite, memWrite, halt, iCacheReq, iCacheHit, dCacheReq, dCacheHit,
    input  clear, rdSel,
    output rdData, halted, haltPulse
  );
endinterface

// File: rtl/perf_monitor.sv
// Purpose: counts cycles, retired instructions and cache traffic until halt; saturating counters with sticky flags.
// Latency: event at edge N lands in its counter at edge N, visible on rdData after edge N+1.
// Backpressure: none; monitor never stalls the pipeline, read port never disturbs counting.
module perf_monitor #(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  perf_monitor_if.slave bus
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  pulse_nxt;
  logic                  halt_pulse;
  logic [5:0]            inc;
  logic [5:0][CNT_W-1:0] cnt;
  logic [5:0]            ovf;
  logic                  hit_no_req;
  logic                  proto_err;
  logic [CNT_W-1:0]      rd_nxt;
  logic [CNT_W-1:0]      rd_q;

  // Next state: clear always wins and lands in RUN; halt only matters while running.
  always_comb begin
    state_nxt = state;
    pulse_nxt = 1'b0;
    if (bus.clear) begin
      state_nxt = RUN;
    end else if (state == RUN && bus.halt) begin
      state_nxt = HALTED;
      pulse_nxt = 1'b1;
    end
  end

  // State register and the one-cycle halt notification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      halt_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      halt_pulse <= pulse_nxt;
    end
  end

  // Per-counter increment requests; order matches the read select encoding 0..5.
  always_comb begin
    inc       = '0;
    proto_err = 1'b0;
    if (state == RUN) begin
      inc[0]    = 1'b1;
      inc[1]    = bus.halt | bus.regWrite | bus.memWrite;
      inc[2]    = bus.iCacheReq;
      inc[3]    = bus.iCacheHit;
      inc[4]    = bus.dCacheReq;
      inc[5]    = bus.dCacheHit;
      proto_err = (bus.iCacheHit & ~bus.iCacheReq) | (bus.dCacheHit & ~bus.dCacheReq);
    end
  end

  // Saturating counters; an increment attempted at all-ones holds and marks overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      ovf        <= '0;
      hit_no_req <= 1'b0;
    end else if (bus.clear) begin
      cnt        <= '0;
      ovf        <= '0;
      hit_no_req <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (inc[i]) begin
          if (cnt[i] == {CNT_W{1'b1}}) begin
            ovf[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end
      end
      if (proto_err) begin
        hit_no_req <= 1'b1;
      end
    end
  end

  // Read mux over the current register contents.
  always_comb begin
    rd_nxt = '0;
    case (bus.rdSel)
      3'd0: rd_nxt = cnt[0];
      3'd1: rd_nxt = cnt[1];
      3'd2: rd_nxt = cnt[2];
      3'd3: rd_nxt = cnt[3];
      3'd4: rd_nxt = cnt[4];
      3'd5: rd_nxt = cnt[5];
      3'd6: rd_nxt[5:0] = ovf;
      default: rd_nxt[2:0] = {(|ovf), hit_no_req, (state == HALTED)};
    endcase
  end

  // Registered read data, decoupling debug logic from the counter update path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_nxt;
    end
  end

  assign bus.rdData    = rd_q;
  assign bus.halted    = (state == HALTED);
  assign bus.haltPulse = halt_pulse;

endmodule

// File: tb/tb_perf_monitor.sv
// Purpose: table-driven check of perf_monitor plus hand sequences for async reset and 8-bit saturation.
// Latency: inputs change #1 after a rising edge, outputs sampled #1 after the next one.
// Backpressure: none.
module tb_perf_monitor;

  localparam logic [7:0] REG = 8'h01;
  localparam logic [7:0] MEM = 8'h02;
  localparam logic [7:0] HLT = 8'h04;
  localparam logic [7:0] IRQ = 8'h08;
  localparam logic [7:0] IHT = 8'h10;
  localparam logic [7:0] DRQ = 8'h20;
  localparam logic [7:0] DHT = 8'h40;
  localparam logic [7:0] CLR = 8'h80;

  typedef struct {
    logic [7:0]  ev;
    logic [2:0]  sel;
    logic [31:0] rd;
    logic        hd;
    logic        hp;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        hd;
    logic        hp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  perf_monitor_if #(.CNT_W(32)) bus_a ();
  perf_monitor_if #(.CNT_W(8))  bus_b ();

  perf_monitor #(.CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  perf_monitor #(.CNT_W(8))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic drive_a(input logic [7:0] ev, input logic [2:0] sel);
    bus_a.regWrite  = ev[0];
    bus_a.memWrite  = ev[1];
    bus_a.halt      = ev[2];
    bus_a.iCacheReq = ev[3];
    bus_a.iCacheHit = ev[4];
    bus_a.dCacheReq = ev[5];
    bus_a.dCacheHit = ev[6];
    bus_a.clear     = ev[7];
    bus_a.rdSel     = sel;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] ev, input logic [2:0] sel, input logic [31:0] rd,
                     input logic hd, input logic hp);
    vecs.push_back('{ev, sel, rd, hd, hp});
  endtask

  initial begin
    exp_t e;

    drive_a(8'h00, 3'd0);
    bus_b.regWrite  = 1'b0;
    bus_b.memWrite  = 1'b0;
    bus_b.halt      = 1'b0;
    bus_b.iCacheReq = 1'b0;
    bus_b.iCacheHit = 1'b0;
    bus_b.dCacheReq = 1'b0;
    bus_b.dCacheHit = 1'b0;
    bus_b.clear     = 1'b0;
    bus_b.rdSel     = 3'd0;

    // Rows 0-12: idle counting, then reads of insts and status.
    for (int k = 0; k < 11; k++) add(8'h00, 3'd0, k, 1'b0, 1'b0);
    add(8'h00, 3'd1, 0, 1'b0, 1'b0);
    add(8'h00, 3'd7, 0, 1'b0, 1'b0);
    // Rows 13-20: three regWrites, a triple retire with halt, then frozen in HALTED.
    add(REG, 3'd1, 0, 1'b0, 1'b0);
    add(REG, 3'd1, 1, 1'b0, 1'b0);
    add(REG, 3'd1, 2, 1'b0, 1'b0);
    add(REG | MEM | HLT, 3'd1, 3, 1'b1, 1'b1);
    add(REG, 3'd1, 4, 1'b1, 1'b0);
    add(REG | HLT, 3'd1, 4, 1'b1, 1'b0);
    add(8'h00, 3'd0, 17, 1'b1, 1'b0);
    add(8'h00, 3'd7, 1, 1'b1, 1'b0);
    // Rows 21-25: clear with halt while HALTED returns to RUN with zeroed counters.
    add(CLR | HLT | REG, 3'd1, 4, 1'b0, 1'b0);
    add(8'h00, 3'd0, 0, 1'b0, 1'b0);
    add(8'h00, 3'd1, 0, 1'b0, 1'b0);
    add(8'h00, 3'd0, 2, 1'b0, 1'b0);
    add(8'h00, 3'd7, 0, 1'b0, 1'b0);
    // Rows 26-36: five icache requests, three hits, one dcache hit without request.
    add(IRQ | IHT, 3'd0, 4, 1'b0, 1'b0);
    add(IRQ, 3'd2, 1, 1'b0, 1'b0);
    add(IRQ | IHT, 3'd3, 1, 1'b0, 1'b0);
    add(IRQ, 3'd2, 3, 1'b0, 1'b0);
    add(IRQ | IHT | DHT, 3'd7, 0, 1'b0, 1'b0);
    add(8'h00, 3'd2, 5, 1'b0, 1'b0);
    add(8'h00, 3'd3, 3, 1'b0, 1'b0);
    add(8'h00, 3'd5, 1, 1'b0, 1'b0);
    add(8'h00, 3'd4, 0, 1'b0, 1'b0);
    add(8'h00, 3'd7, 2, 1'b0, 1'b0);
    add(8'h00, 3'd6, 0, 1'b0, 1'b0);
    // Rows 37-45: clear beats halt in RUN, then paired dcache traffic and a lone store.
    add(CLR | HLT | IRQ, 3'd1, 0, 1'b0, 1'b0);
    add(8'h00, 3'd7, 0, 1'b0, 1'b0);
    add(8'h00, 3'd2, 0, 1'b0, 1'b0);
    add(8'h00, 3'd0, 2, 1'b0, 1'b0);
    add(DRQ | DHT, 3'd0, 3, 1'b0, 1'b0);
    add(8'h00, 3'd4, 1, 1'b0, 1'b0);
    add(8'h00, 3'd7, 0, 1'b0, 1'b0);
    add(MEM, 3'd1, 0, 1'b0, 1'b0);
    add(8'h00, 3'd1, 1, 1'b0, 1'b0);

    #12;
    check("reset_rdData", bus_a.rdData, 0);
    check("reset_halted", {31'd0, bus_a.halted}, 0);
    check("reset_haltPulse", {31'd0, bus_a.haltPulse}, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive_a(vecs[i].ev, vecs[i].sel);
      sb.push_back('{$sformatf("row%0d", i), vecs[i].rd, vecs[i].hd, vecs[i].hp});
      tick();
      e = sb.pop_front();
      check({e.name, "_rdData"}, bus_a.rdData, e.rd);
      check({e.name, "_halted"}, {31'd0, bus_a.halted}, {31'd0, e.hd});
      check({e.name, "_haltPulse"}, {31'd0, bus_a.haltPulse}, {31'd0, e.hp});
    end

    // Halt, then assert reset between edges and look before the next edge.
    drive_a(HLT, 3'd0);
    tick();
    check("pre_rst_rdData", bus_a.rdData, 8);
    check("pre_rst_halted", {31'd0, bus_a.halted}, 1);
    drive_a(8'h00, 3'd0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rdData", bus_a.rdData, 0);
    check("async_rst_halted", {31'd0, bus_a.halted}, 0);
    check("async_rst_haltPulse", {31'd0, bus_a.haltPulse}, 0);
    #1;
    rst = 1'b0;
    for (int s = 1; s < 6; s++) begin
      drive_a(8'h00, 3'(s));
      tick();
      check($sformatf("post_rst_sel%0d", s), bus_a.rdData, 0);
    end
    drive_a(8'h00, 3'd0);
    tick();
    check("post_rst_cycles", bus_a.rdData, 5);

    // 8-bit instance: saturation of the cycle counter.
    bus_b.clear = 1'b1;
    tick();
    bus_b.clear = 1'b0;
    repeat (300) tick();
    bus_b.rdSel = 3'd0;
    tick();
    check("sat_cycles", {24'd0, bus_b.rdData}, 255);
    bus_b.rdSel = 3'd6;
    tick();
    check("sat_ovf_flags", {24'd0, bus_b.rdData}, 1);
    bus_b.rdSel = 3'd7;
    tick();
    check("sat_status", {24'd0, bus_b.rdData}, 4);
    check("sat_halted", {31'd0, bus_b.halted}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/perf_monitor.md
# perf_monitor

Synthesizable performance and retirement monitor that sits beside the pipeline's writeback and memory stages. It consumes the per-cycle retirement and cache strobes the processor exposes, and accumulates cycle, instruction and cache statistics. It freezes all counts when the processor halts. A registered read port exposes the results to on-chip debug logic, replacing simulation-only counting.

## Interface
Parameters:
- CNT_W, 32, width of every counter (minimum 8).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- regWrite  in  1  register-file write retiring this cycle (writeback stage).
- memWrite  in  1  store committing this cycle; already qualified by memory-stage not-stalled.
- halt  in  1  halt instruction in writeback this cycle.
- iCacheReq  in  1  valid instruction-cache request completed this cycle.
- iCacheHit  in  1  instruction-cache hit this cycle.
- dCacheReq  in  1  valid data-cache request completed this cycle.
- dCacheHit  in  1  data-cache hit this cycle.
- clear  in  1  synchronous clear of all counters and flags; returns to RUN.
- rdSel  in  3  read select: 0 cycles, 1 insts, 2 iReq, 3 iHit, 4 dReq, 5 dHit, 6 overflow flags, 7 status.
- rdData  out  CNT_W  registered read data.
- halted  out  1  high while in HALTED.
- haltPulse  out  1  one-cycle pulse on the cycle after halt is sampled in RUN.

## Operation
- State machine with two states:
  - RUN → HALTED when halt=1 is sampled in RUN.
  - HALTED → RUN only on clear=1.
  - HALTED ignores all event inputs, including further halt.
- Counters, evaluated in RUN only:
  - cycles: +1 every RUN cycle.
  - insts: +1 when (halt | regWrite | memWrite). At most 1 per cycle even if several inputs are high.
  - iReq, iHit, dReq, dHit: +1 when the matching input is high.
- The cycle that samples halt is itself counted. Cycle and instruction counters include it; cache strobes sampled that same cycle are also counted.
- Saturation: a counter at all-ones holds and sets its sticky overflow bit. Overflow bits occupy rdData[5:0] at rdSel=6 in counter order 0..5; upper bits read 0.
- Protocol error: iCacheHit=1 with iCacheReq=0, or dCacheHit=1 with dCacheReq=0, in RUN sets the sticky flag hitNoReq. The hit is still counted.
- Status word (rdSel=7):
  - bit0 halted
  - bit1 hitNoReq
  - bit2 any overflow bit set
  - remaining bits 0
- clear has priority over every event and over halt in the same cycle. The next state is RUN with all counters, overflow bits and hitNoReq at 0. Events in the clear cycle are discarded.
- Read port does not disturb counting. rdData reflects counter values as of the end of the previous cycle's update.

## Timing
- Reset values:
  - state RUN
  - all counters 0, all flags 0
  - rdData 0, halted 0, haltPulse 0
- Counting begins on the first rising edge after rst deasserts.
- Event sampled at edge N appears in the counter after edge N. It is visible on rdData after edge N+1, giving 1-cycle read latency from rdSel change to rdData.
- halt sampled at edge N: halted=1 and haltPulse=1 after edge N. haltPulse=0 after edge N+1.
- rst asserted mid-run clears everything immediately, without waiting for clk.
- Counter increment is modulo-free: saturating as described, never wrapping.

## Test plan
- Reset, then 10 idle RUN cycles, then rdSel=0 → rdData=10; insts=0; status=0.
- regWrite+memWrite+halt all high for 1 cycle, plus 3 earlier regWrite cycles → insts=4; halted=1; haltPulse high exactly 1 cycle; further regWrite does not change insts.
- iCacheReq for 5 cycles, iCacheHit on 3 of them; dCacheHit once with dCacheReq=0 → iReq=5, iHit=3, dHit=1, status bit1=1.
- CNT_W=8, 300 RUN cycles → cycles=255; rdSel=6 bit0=1; status bit2=1.
- In HALTED, clear and halt asserted together → next cycle state RUN, all counters 0, halted=0; counting resumes.
- Assert rst asynchronously between clock edges mid-count → rdData, halted and all counters 0 before the next edge.
